// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_ctrl storage block.
// Holds the FSM state encoding, legal read-latency bounds and depth helper.
package mem_pkg;

  localparam int RLAT_MIN = 1;
  localparam int RLAT_MAX = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic int depth_f(input int aw);
    return 32'sd1 << aw;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read return pipeline: stage 0 captures the word at the acceptance edge,
// RLAT-1 further stages delay it; data only moves with a valid bit so rdata holds.
module mem_rd_pipe #(
  parameter int DWIDTH = 8,
  parameter int RLAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              rvalid,
  output logic [DWIDTH-1:0] rdata
);

  logic [RLAT-1:0]   vld_r;
  logic [DWIDTH-1:0] dat_r [RLAT];

  // Valid/data shift register; a stage's data only updates when a valid word enters it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      for (int i = 0; i < RLAT; i++) begin
        dat_r[i] <= '0;
      end
    end else begin
      vld_r[0] <= in_valid;
      if (in_valid) begin
        dat_r[0] <= in_data;
      end
      for (int i = 1; i < RLAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) begin
          dat_r[i] <= dat_r[i-1];
        end
      end
    end
  end

  assign rvalid = vld_r[RLAT-1];
  assign rdata  = dat_r[RLAT-1];

endmodule

// File: rtl/mem_ctrl.sv
// Single-port synchronous memory with ready handshake, configurable read
// latency and a hardware clear sweep that writes INIT_VAL to every entry.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int                AWIDTH   = 5,
  parameter int                DWIDTH   = 8,
  parameter int                RLAT     = 1,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic              ready,
  input  logic              clr,
  output logic              busy,
  output logic              clr_done,
  output logic              rvalid,
  output logic [DWIDTH-1:0] rdata
);

  localparam int DEPTH = depth_f(AWIDTH);

  if ((RLAT < RLAT_MIN) || (RLAT > RLAT_MAX)) begin : g_bad_rlat
    $error("mem_ctrl: RLAT must lie in 1..4");
  end

  state_t            state_r;
  logic [AWIDTH-1:0] cnt_r;
  logic              clr_done_r;
  logic [DWIDTH-1:0] mem_r [DEPTH];

  logic              acc_s;
  logic              rd_acc_s;
  logic              wr_en_s;
  logic [AWIDTH-1:0] wr_addr_s;
  logic [DWIDTH-1:0] wr_data_s;
  logic [DWIDTH-1:0] rd_word_s;

  assign acc_s     = req && (state_r == IDLE);
  assign rd_acc_s  = acc_s && !wr;
  assign rd_word_s = mem_r[addr];

  // The single write port is owned by the sweep while clearing, by the request otherwise
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = '0;
    wr_data_s = '0;
    if (state_r == CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = cnt_r;
      wr_data_s = INIT_VAL;
    end else begin
      wr_en_s   = acc_s && wr;
      wr_addr_s = addr;
      wr_data_s = wdata;
    end
  end

  // Storage array, deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Clear FSM and sweep counter; the counter wraps to zero on the final write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      clr_done_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          clr_done_r <= 1'b0;
          if (clr) begin
            state_r <= CLEAR;
            cnt_r   <= '0;
          end
        end
        CLEAR: begin
          cnt_r <= cnt_r + AWIDTH'(1);
          if (cnt_r == '1) begin
            state_r    <= IDLE;
            clr_done_r <= 1'b1;
          end else begin
            clr_done_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          clr_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = (state_r == IDLE);
  assign busy     = (state_r == CLEAR);
  assign clr_done = clr_done_r;

  mem_rd_pipe #(
    .DWIDTH (DWIDTH),
    .RLAT   (RLAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_acc_s),
    .in_data  (rd_word_s),
    .rvalid   (rvalid),
    .rdata    (rdata)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: two instances (RLAT=1 and RLAT=3) share stimulus,
// read returns are scheduled in per-instance queues with their due cycle.
module tb_mem_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       wr;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       clr;

  logic       ready1, busy1, clr_done1, rvalid1;
  logic [7:0] rdata1;
  logic       ready3, busy3, clr_done3, rvalid3;
  logic [7:0] rdata3;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t       q1[$];
  exp_t       q3[$];
  logic [7:0] last1;
  logic [7:0] last3;
  int         cyc;
  int         n_checks;
  int         n_err;
  bit         mon_en;

  mem_ctrl #(.AWIDTH(5), .DWIDTH(8), .RLAT(1), .INIT_VAL(8'hA5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready1), .clr(clr), .busy(busy1), .clr_done(clr_done1),
    .rvalid(rvalid1), .rdata(rdata1)
  );

  mem_ctrl #(.AWIDTH(5), .DWIDTH(8), .RLAT(3), .INIT_VAL(8'hA5)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready3), .clr(clr), .busy(busy3), .clr_done(clr_done3),
    .rvalid(rvalid3), .rdata(rdata3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_ready1"}, 8'(ready1), 8'd1);
    check({tag, "_ready3"}, 8'(ready3), 8'd1);
    check({tag, "_busy1"}, 8'(busy1), 8'd0);
    check({tag, "_busy3"}, 8'(busy3), 8'd0);
    check({tag, "_done1"}, 8'(clr_done1), 8'd0);
    check({tag, "_done3"}, 8'(clr_done3), 8'd0);
  endtask

  task automatic chk_rd_zero(input string tag);
    check({tag, "_rvalid1"}, 8'(rvalid1), 8'd0);
    check({tag, "_rvalid3"}, 8'(rvalid3), 8'd0);
    check({tag, "_rdata1"}, rdata1, 8'h00);
    check({tag, "_rdata3"}, rdata3, 8'h00);
  endtask

  // Advance to the next falling edge and check the read return of both instances
  task automatic tick();
    bit v;
    @(negedge clk);
    if (mon_en) begin
      v = (q1.size() > 0) && (q1[0].due == cyc);
      check("rvalid_l1", 8'(rvalid1), 8'(v));
      if (v) begin
        last1 = q1[0].data;
        void'(q1.pop_front());
      end
      check("rdata_l1", rdata1, last1);
      v = (q3.size() > 0) && (q3[0].due == cyc);
      check("rvalid_l3", 8'(rvalid3), 8'(v));
      if (v) begin
        last3 = q3[0].data;
        void'(q3.pop_front());
      end
      check("rdata_l3", rdata3, last3);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      req = 1'b0;
      wr  = 1'b0;
      clr = 1'b0;
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    tick();
    req   = 1'b1;
    wr    = 1'b1;
    addr  = a;
    wdata = d;
    clr   = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [7:0] exp);
    exp_t e;
    tick();
    req  = 1'b1;
    wr   = 1'b0;
    addr = a;
    clr  = 1'b0;
    e.data = exp;
    e.due  = cyc + 1;
    q1.push_back(e);
    e.due  = cyc + 3;
    q3.push_back(e);
  endtask

  // Observe a sweep that was started on the edge just before this call
  task automatic sweep_watch(input bit inject, input string tag);
    int nb1 = 0, nb3 = 0, nrdy = 0, nd1 = 0, nd3 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy1) nb1++;
      if (busy3) nb3++;
      if ((busy1 && ready1) || (busy3 && ready3)) nrdy++;
      if (clr_done1) nd1++;
      if (clr_done3) nd3++;
      if (i == 32) begin
        check({tag, "_done_end1"}, 8'(clr_done1), 8'd1);
        check({tag, "_done_end3"}, 8'(clr_done3), 8'd1);
      end
      req = 1'b0;
      wr  = 1'b0;
      clr = 1'b0;
      if (inject && (i == 5)) begin
        clr   = 1'b1;
        req   = 1'b1;
        wr    = 1'b1;
        addr  = 5'd2;
        wdata = 8'h77;
      end
      if (inject && (i == 6)) begin
        req  = 1'b1;
        addr = 5'd2;
      end
    end
    check({tag, "_busy_cyc1"}, 8'(nb1), 8'd32);
    check({tag, "_busy_cyc3"}, 8'(nb3), 8'd32);
    check({tag, "_ready_in_sweep"}, 8'(nrdy), 8'd0);
    check({tag, "_done_cnt1"}, 8'(nd1), 8'd1);
    check({tag, "_done_cnt3"}, 8'(nd3), 8'd1);
  endtask

  initial begin
    int nd;
    logic [7:0] v;
    n_checks = 0;
    n_err    = 0;
    mon_en   = 1'b0;
    last1    = 8'h00;
    last3    = 8'h00;
    rst_n    = 1'b0;
    req      = 1'b0;
    wr       = 1'b0;
    addr     = 5'd0;
    wdata    = 8'h00;
    clr      = 1'b0;

    repeat (3) @(negedge clk);
    chk_idle("in_rst");
    chk_rd_zero("in_rst");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);
    chk_idle("post_rst");

    // Boundary addresses, back-to-back reads
    do_write(5'd0, 8'hFF);
    do_write(5'd31, 8'h00);
    do_read(5'd0, 8'hFF);
    do_read(5'd31, 8'h00);
    idle(5);

    // Descending-address burst with req held high
    for (int d = 0; d < 31; d++) do_write(5'(31 - d), 8'(d));
    for (int d = 0; d < 31; d++) do_read(5'(31 - d), 8'(d));
    idle(5);

    // Clear pulse together with an accepted write
    tick();
    req   = 1'b1;
    wr    = 1'b1;
    addr  = 5'd4;
    wdata = 8'h3C;
    clr   = 1'b1;
    sweep_watch(1'b0, "sw1");
    chk_idle("sw1_after");
    do_read(5'd0, 8'hA5);
    do_read(5'd4, 8'hA5);
    do_read(5'd31, 8'hA5);
    idle(5);

    // Read in flight across the clear start; req and clr ignored mid-sweep
    do_write(5'd7, 8'h11);
    do_read(5'd7, 8'h11);
    tick();
    req = 1'b0;
    clr = 1'b1;
    sweep_watch(1'b1, "sw2");
    do_read(5'd2, 8'hA5);
    do_read(5'd7, 8'hA5);
    idle(5);

    // Reset ten cycles into a sweep
    for (int a = 0; a < 32; a++) begin
      v = (a < 10) ? 8'(8'h50 + a) : 8'(a);
      do_write(5'(a), v);
    end
    idle(1);
    tick();
    clr = 1'b1;
    @(posedge clk);
    tick();
    clr = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk_rd_zero("mid_rst");
    last1 = 8'h00;
    last3 = 8'h00;
    q1.delete();
    q3.delete();
    tick();
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (clr_done1 || clr_done3) nd++;
    end
    check("no_done_after_rst", 8'(nd), 8'd0);
    chk_idle("after_abort");
    for (int a = 0; a < 32; a++) begin
      v = (a < 10) ? 8'hA5 : 8'(a);
      do_read(5'(a), v);
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
